// File: rtl/core_mdu_pkg.sv
// Shared definitions for the multiply/divide unit: datapath width, instruction
// size, funct3 op-codes, FSM state encodings and a word sign-extension helper.
package core_mdu_pkg;

  localparam int unsigned MDU_XLEN       = 64;
  localparam int unsigned CPU_INSTR_SIZE = 32;

  // funct3 of the M-extension instructions
  typedef enum logic [2:0] {
    MDU_OP_MUL    = 3'd0,
    MDU_OP_MULH   = 3'd1,
    MDU_OP_MULHSU = 3'd2,
    MDU_OP_MULHU  = 3'd3,
    MDU_OP_DIV    = 3'd4,
    MDU_OP_DIVU   = 3'd5,
    MDU_OP_REM    = 3'd6,
    MDU_OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'd0,
    MDU_ST_RUN  = 2'd1,
    MDU_ST_DONE = 2'd2
  } mdu_state_e;

  // Sign-extend the low 32 bits of a 64-bit value
  function automatic logic [63:0] mdu_sext_w(input logic [63:0] x);
    return {{32{x[31]}}, x[31:0]};
  endfunction

endpackage

// File: rtl/core_mdu_div.sv
// Restoring divider datapath working on unsigned magnitudes. One quotient bit
// per step; the owner sequences load/step and applies sign fix-up. For word
// operations the 32-bit dividend is pre-shifted into the top half so that 32
// steps leave the quotient in the low half.
module core_mdu_div
  import core_mdu_pkg::*;
#(
  parameter int unsigned XLEN = MDU_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_nxt_o,
  output logic [XLEN-1:0] rem_nxt_o
);

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dsr_q;
  logic [XLEN:0]   rem_sh_s;
  logic [XLEN+1:0] trial_s;
  logic            ge_s;

  // One restoring step: shift in the next dividend bit, try to subtract
  always_comb begin
    rem_sh_s = {rem_q, quo_q[XLEN-1]};
    trial_s  = {1'b0, rem_sh_s} - {2'b00, dsr_q};
    // both top bits are zero exactly when the trial subtraction did not borrow
    ge_s      = ~(trial_s[XLEN+1] | trial_s[XLEN]);
    quo_nxt_o = {quo_q[XLEN-2:0], ge_s};
    if (ge_s) begin
      rem_nxt_o = trial_s[XLEN-1:0];
    end else begin
      rem_nxt_o = rem_sh_s[XLEN-1:0];
    end
  end

  // Partial remainder / quotient / divisor registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= word_i ? {dividend_i[31:0], {(XLEN-32){1'b0}}} : dividend_i;
      dsr_q <= divisor_i;
    end else if (step_i) begin
      rem_q <= rem_nxt_o;
      quo_q <= quo_nxt_o;
    end
  end

endmodule

// File: rtl/core_mdu.sv
// Iterative RV64 M-extension multiply/divide unit. Radix-2 shift-add multiply
// and restoring divide (core_mdu_div) on operand magnitudes, followed by sign
// fix-up. Divide-by-zero and signed overflow finish without RUN cycles.
// Optional W-variant support is compiled in with CORE_MDU_WORD_EN.
module core_mdu
  import core_mdu_pkg::*;
#(
  parameter int unsigned XLEN = MDU_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  mdu_state_e        state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [5:0]        last_s;
  logic [XLEN-1:0]   result_q, result_d;
  mdu_op_e           op_q;
  logic              word_q;
  logic              neg_a_q;
  logic              neg_b_q;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] acc_q;

  logic              accept_s, step_s;
  logic              word_eff_s, signed1_s, signed2_s, sign1_s, sign2_s;
  logic              div_zero_s, div_ovf_s, special_s;
  logic [XLEN-1:0]   op1_x_s, op2_x_s, mag1_s, mag2_s, int_min_s;
  logic [XLEN-1:0]   spec_raw_s, spec_res_s;
  logic [XLEN:0]     mul_sum_s;
  logic [2*XLEN-1:0] acc_nxt_s, prod_s, prod_fix_s;
  logic [XLEN-1:0]   quo_nxt_s, rem_nxt_s, quo_fix_s, rem_fix_s;
  logic [XLEN-1:0]   run_raw_s, run_res_s;

`ifdef CORE_MDU_WORD_EN
  // W variants exist only for MUL and the divide ops
  assign word_eff_s = word_i & ((op_i == MDU_OP_MUL) | op_i[2]);
`else
  // word_i stays on the port for pin compatibility but has no effect
  assign word_eff_s = word_i & 1'b0;
`endif

  // Operand signedness per op
  always_comb begin
    signed1_s = 1'b0;
    signed2_s = 1'b0;
    case (op_i)
      MDU_OP_MUL, MDU_OP_MULH, MDU_OP_DIV, MDU_OP_REM: begin
        signed1_s = 1'b1;
        signed2_s = 1'b1;
      end
      MDU_OP_MULHSU: begin
        signed1_s = 1'b1;
        signed2_s = 1'b0;
      end
      default: begin
        signed1_s = 1'b0;
        signed2_s = 1'b0;
      end
    endcase
  end

  // Operand extension, magnitudes and special-case detection
  always_comb begin
    op1_x_s = src1_i;
    op2_x_s = src2_i;
    if (word_eff_s) begin
      op1_x_s = signed1_s ? mdu_sext_w(src1_i) : {{(XLEN-32){1'b0}}, src1_i[31:0]};
      op2_x_s = signed2_s ? mdu_sext_w(src2_i) : {{(XLEN-32){1'b0}}, src2_i[31:0]};
    end else begin
      op1_x_s = src1_i;
      op2_x_s = src2_i;
    end
    sign1_s   = signed1_s & op1_x_s[XLEN-1];
    sign2_s   = signed2_s & op2_x_s[XLEN-1];
    mag1_s    = sign1_s ? -op1_x_s : op1_x_s;
    mag2_s    = sign2_s ? -op2_x_s : op2_x_s;
    int_min_s = word_eff_s ? {{(XLEN-31){1'b1}}, 31'd0} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero_s = op_i[2] & (op2_x_s == {XLEN{1'b0}});
    div_ovf_s  = op_i[2] & signed1_s & (op1_x_s == int_min_s) & (&op2_x_s);
    special_s  = div_zero_s | div_ovf_s;
    if (div_zero_s) begin
      spec_raw_s = op_i[1] ? op1_x_s : {XLEN{1'b1}};
    end else begin
      spec_raw_s = op_i[1] ? {XLEN{1'b0}} : op1_x_s;
    end
    spec_res_s = word_eff_s ? mdu_sext_w(spec_raw_s) : spec_raw_s;
  end

  // Multiplier step, product selection and sign fix-up of the final iteration
  always_comb begin
    mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    acc_nxt_s  = {mul_sum_s, acc_q[XLEN-1:1]};
    // after 32 steps the product sits 32 bits higher than after 64
    prod_s     = word_q ? {32'd0, acc_nxt_s[2*XLEN-1:32]} : acc_nxt_s;
    prod_fix_s = neg_a_q ? -prod_s : prod_s;
    quo_fix_s  = neg_a_q ? -quo_nxt_s : quo_nxt_s;
    rem_fix_s  = neg_b_q ? -rem_nxt_s : rem_nxt_s;
    case (op_q)
      MDU_OP_MUL:                             run_raw_s = prod_fix_s[XLEN-1:0];
      MDU_OP_MULH, MDU_OP_MULHSU, MDU_OP_MULHU: run_raw_s = prod_fix_s[2*XLEN-1:XLEN];
      MDU_OP_DIV, MDU_OP_DIVU:                run_raw_s = quo_fix_s;
      MDU_OP_REM, MDU_OP_REMU:                run_raw_s = rem_fix_s;
      default:                                run_raw_s = {XLEN{1'b0}};
    endcase
    run_res_s = word_q ? mdu_sext_w(run_raw_s) : run_raw_s;
    last_s    = word_q ? 6'd31 : 6'd63;
  end

  // Next-state, iteration count and result capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    accept_s = 1'b0;
    step_s   = 1'b0;
    case (state_q)
      MDU_ST_IDLE, MDU_ST_DONE: begin
        if (flush_i) begin
          state_d = MDU_ST_IDLE;
          cnt_d   = 6'd0;
        end else if (start_i) begin
          accept_s = 1'b1;
          cnt_d    = 6'd0;
          if (special_s) begin
            state_d  = MDU_ST_DONE;
            result_d = spec_res_s;
          end else begin
            state_d = MDU_ST_RUN;
          end
        end else begin
          state_d = MDU_ST_IDLE;
        end
      end
      MDU_ST_RUN: begin
        if (flush_i) begin
          state_d = MDU_ST_IDLE;
          cnt_d   = 6'd0;
        end else begin
          step_s = 1'b1;
          if (cnt_q == last_s) begin
            state_d  = MDU_ST_DONE;
            cnt_d    = 6'd0;
            result_d = run_res_s;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = MDU_ST_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // FSM, counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MDU_ST_IDLE;
      cnt_q    <= 6'd0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Operation context and multiplier accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= MDU_OP_MUL;
      word_q  <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else if (accept_s) begin
      op_q    <= mdu_op_e'(op_i);
      word_q  <= word_eff_s;
      neg_a_q <= sign1_s ^ sign2_s;
      neg_b_q <= sign1_s;
      mcand_q <= mag1_s;
      acc_q   <= {{XLEN{1'b0}}, mag2_s};
    end else if (step_s & ~op_q[2]) begin
      acc_q <= acc_nxt_s;
    end
  end

  core_mdu_div #(
    .XLEN(XLEN)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept_s),
    .step_i     (step_s & op_q[2]),
    .word_i     (word_eff_s),
    .dividend_i (mag1_s),
    .divisor_i  (mag2_s),
    .quo_nxt_o  (quo_nxt_s),
    .rem_nxt_o  (rem_nxt_s)
  );

  assign busy_o   = (state_q == MDU_ST_RUN);
  assign done_o   = (state_q == MDU_ST_DONE);
  assign result_o = result_q;

endmodule
